// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair
// (polynomial x^8+x^6+x^5+x^4+1, Fibonacci form).
package lfsr_pkg;

    localparam int               LFSR_W = 8;
    localparam logic [LFSR_W-1:0] SEED  = 8'h2A;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } chk_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating accumulator with synchronous clear; a clear coinciding with an
// increment yields the increment alone.
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     count_o
);

    logic [W-1:0] base;
    logic [W:0]   sum;

    assign base = clear_i ? '0 : count_o;
    assign sum  = {1'b0, base} + (W+1)'(inc_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     count_o <= '0;
        else if (sum[W]) count_o <= '1;
        else             count_o <= sum[W-1:0];
    end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises, locks, flywheels and counts
// mismatching words. Define LFSR_CHECKER_BITERR_EN to add a bit-error counter.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [7:0]        data_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_count_o
`ifdef LFSR_CHECKER_BITERR_EN
   ,output logic [CNT_W-1:0]  bit_err_count_o
`endif
);

    localparam logic [3:0] LOCK_C   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_COUNT);

    chk_state_e        state_q, state_d;
    logic [LFSR_W-1:0] prev_q, prev_d, exp_w;
    logic [3:0]        match_q, match_d, miss_q, miss_d;
    logic              err_q, err_d;

    assign exp_w = lfsr_next(prev_q);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (valid_i) begin
            case (state_q)
                SEARCH: begin
                    // all-zero is the LFSR lock-up word and can never seed a stream
                    if (data_i != '0) begin
                        prev_d  = data_i;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_i == exp_w) begin
                        prev_d  = data_i;
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 >= LOCK_C) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (data_i != '0) begin
                        prev_d  = data_i;
                        match_d = '0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    prev_d = exp_w;
                    if (data_i == exp_w) begin
                        miss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + 4'd1;
                        if (miss_q + 4'd1 >= UNLOCK_C) begin
                            state_d = SEARCH;
                            miss_d  = '0;
                            match_d = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEARCH;
            prev_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    assign locked_o = (state_q == LOCKED);
    assign err_o    = err_q;

    sat_counter #(.W(CNT_W), .INC_W(1)) u_err_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .inc_i   (err_d),
        .count_o (err_count_o)
    );

`ifdef LFSR_CHECKER_BITERR_EN
    logic [3:0] bit_inc;

    assign bit_inc = err_d ? 4'($countones(data_i ^ exp_w)) : 4'd0;

    sat_counter #(.W(CNT_W), .INC_W(4)) u_bit_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .inc_i   (bit_inc),
        .count_o (bit_err_count_o)
    );
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a default-width instance and a 4-bit
// counter instance share one stimulus stream.
module tb_lfsr_checker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        clear_i;
    logic        locked_o, err_o, locked_s, err_s;
    logic [15:0] err_count_o;
    logic [3:0]  err_count_s;
`ifdef LFSR_CHECKER_BITERR_EN
    logic [15:0] bit_err_count_o;
    logic [3:0]  bit_err_count_s;
`endif

    int npass = 0;
    int ntot  = 0;

    always #5 clk_i = ~clk_i;

    lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
        .clear_i(clear_i), .locked_o(locked_o), .err_o(err_o),
        .err_count_o(err_count_o)
`ifdef LFSR_CHECKER_BITERR_EN
       ,.bit_err_count_o(bit_err_count_o)
`endif
    );

    lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .CNT_W(4)) dut_s (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
        .clear_i(clear_i), .locked_o(locked_s), .err_o(err_s),
        .err_count_o(err_count_s)
`ifdef LFSR_CHECKER_BITERR_EN
       ,.bit_err_count_o(bit_err_count_s)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // one accepted edge; outputs are sampled 1ns after it
    task automatic beat(input logic v, input logic [7:0] d, input logic clr);
        @(negedge clk_i);
        valid_i = v; data_i = d; clear_i = clr;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0; clear_i = 1'b0;
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    logic [7:0] cur;

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; clear_i = 1'b0;
        #2;
        chk("rst_locked", 32'(locked_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_cnt", 32'(err_count_o), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // lock-up word must not leave SEARCH
        for (int i = 0; i < 10; i++) beat(1'b1, 8'h00, 1'b0);
        chk("zero_locked", 32'(locked_o), 0);
        beat(1'b1, 8'h2A, 1'b0);
        beat(1'b1, 8'h54, 1'b0);
        beat(1'b1, 8'hA9, 1'b0);
        beat(1'b1, 8'h53, 1'b0);
        chk("prelock", 32'(locked_o), 0);
        beat(1'b1, 8'hA7, 1'b0);
        chk("lock", 32'(locked_o), 1);
        chk("lock_cnt", 32'(err_count_o), 0);

        // single error then correct continuation
        beat(1'b1, 8'hFF, 1'b0);
        chk("se_err", 32'(err_o), 1);
        chk("se_cnt", 32'(err_count_o), 1);
        chk("se_locked", 32'(locked_o), 1);
`ifdef LFSR_CHECKER_BITERR_EN
        chk("se_bits", 32'(bit_err_count_o), 4);
`endif
        beat(1'b1, 8'h9D, 1'b0);
        chk("se_next_err", 32'(err_o), 0);
        beat(1'b1, 8'h3B, 1'b0);
        beat(1'b1, 8'h77, 1'b0);
        chk("se_cnt2", 32'(err_count_o), 1);
        chk("se_locked2", 32'(locked_o), 1);

        // idle clear, lock state untouched
        beat(1'b0, 8'h00, 1'b1);
        chk("clr_cnt", 32'(err_count_o), 0);
        chk("clr_locked", 32'(locked_o), 1);

        // three misses drop lock; third one still counted
        beat(1'b1, 8'h00, 1'b0);
        chk("ll1_cnt", 32'(err_count_o), 1);
        chk("ll1_locked", 32'(locked_o), 1);
        beat(1'b1, 8'h01, 1'b0);
        chk("ll2_cnt", 32'(err_count_o), 2);
        beat(1'b1, 8'h02, 1'b0);
        chk("ll3_cnt", 32'(err_count_o), 3);
        chk("ll3_err", 32'(err_o), 1);
        chk("ll3_locked", 32'(locked_o), 0);
`ifdef LFSR_CHECKER_BITERR_EN
        chk("ll_bits", 32'(bit_err_count_o), 16);
        chk("ll_bits_sat", 32'(bit_err_count_s), 15);
`endif

        // relock with gaps carrying garbage data
        beat(1'b1, 8'h2A, 1'b0);
        beat(1'b0, 8'hFF, 1'b0);
        beat(1'b1, 8'h54, 1'b0);
        beat(1'b0, 8'h13, 1'b0);
        beat(1'b1, 8'hA9, 1'b0);
        beat(1'b0, 8'hFF, 1'b0);
        beat(1'b1, 8'h53, 1'b0);
        beat(1'b0, 8'h00, 1'b0);
        chk("gap_prelock", 32'(locked_o), 0);
        chk("gap_err", 32'(err_o), 0);
        beat(1'b1, 8'hA7, 1'b0);
        chk("gap_lock", 32'(locked_o), 1);
        beat(1'b0, 8'h55, 1'b0);
        chk("gap_idle_err", 32'(err_o), 0);
        chk("gap_idle_cnt", 32'(err_count_o), 3);

        // clear coincident with an error: clear first, then count
        beat(1'b1, 8'h4F, 1'b1);
        chk("clr_err_cnt", 32'(err_count_o), 1);
        chk("clr_err_cnt_s", 32'(err_count_s), 1);
        chk("clr_err_pulse", 32'(err_o), 1);
`ifdef LFSR_CHECKER_BITERR_EN
        chk("clr_bits", 32'(bit_err_count_o), 1);
`endif

        // 20 further mismatches interleaved with correct words
        cur = 8'h4E;
        for (int i = 0; i < 20; i++) begin
            cur = ref_next(cur);
            beat(1'b1, cur ^ 8'h01, 1'b0);
            cur = ref_next(cur);
            beat(1'b1, cur, 1'b0);
        end
        chk("sat_cnt_s", 32'(err_count_s), 15);
        chk("sat_cnt", 32'(err_count_o), 21);
        chk("sat_locked", 32'(locked_o), 1);
`ifdef LFSR_CHECKER_BITERR_EN
        chk("sat_bits", 32'(bit_err_count_o), 21);
        chk("sat_bits_s", 32'(bit_err_count_s), 15);
`endif

        // asynchronous reset between edges
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_locked", 32'(locked_o), 0);
        chk("arst_cnt", 32'(err_count_o), 0);
        chk("arst_cnt_s", 32'(err_count_s), 0);
`ifdef LFSR_CHECKER_BITERR_EN
        chk("arst_bits", 32'(bit_err_count_o), 0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        beat(1'b1, 8'h9D, 1'b0);
        chk("post_rst_locked", 32'(locked_o), 0);
        chk("post_rst_err", 32'(err_o), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
